// File: rtl/pll_lock_reset_seq.sv
// PLL reset / lock qualification sequencer.
// Runs on the free-running board reference clock. It pulses the PLL reset and waits for a
// stable lock. It then releases the system reset. Loss of lock or a software request
// restarts the sequence.
module pll_lock_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W               = 17
) (
    input  logic       i_refclk,
    input  logic       i_rst_n,
    input  logic       i_locked,
    input  logic       i_relock_req,
    output logic       o_pll_rst,
    output logic       o_sys_rst_n,
    output logic       o_ready,
    output logic [7:0] o_lock_lost_cnt,
    output logic [7:0] o_retry_cnt
);

    // Terminal counts for each timed phase; the counter starts at 0 on phase entry.
    localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

    typedef enum logic [1:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StRun
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_ready;
    logic [7:0]       r_lock_lost_cnt;
    logic [7:0]       r_retry_cnt;
    logic             r_locked_meta;
    logic             r_locked_s;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_locked_meta <= 1'b0;
            r_locked_s    <= 1'b0;
        end else begin
            r_locked_meta <= i_locked;
            r_locked_s    <= r_locked_meta;
        end
    end

    // Sequencer FSM with registered outputs; lock loss in RUN outranks relock_req.
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= StPllRst;
            r_cnt           <= '0;
            r_pll_rst       <= 1'b1;
            r_sys_rst_n     <= 1'b0;
            r_ready         <= 1'b0;
            r_lock_lost_cnt <= 8'd0;
            r_retry_cnt     <= 8'd0;
        end else if (r_state == StRun && !r_locked_s) begin
            r_state     <= StPllRst;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            if (r_lock_lost_cnt != 8'hFF) begin
                r_lock_lost_cnt <= r_lock_lost_cnt + 8'd1;
            end
        end else if (i_relock_req) begin
            // Software restart; also restarts an in-progress PLL reset pulse.
            r_state     <= StPllRst;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            unique case (r_state)
                StPllRst: begin
                    if (r_cnt == PllRstLast) begin
                        r_state   <= StWaitLock;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                StWaitLock: begin
                    if (r_locked_s) begin
                        r_state <= StStable;
                        r_cnt   <= '0;
                    end else if (r_cnt == TimeoutLast) begin
                        r_state   <= StPllRst;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        if (r_retry_cnt != 8'hFF) begin
                            r_retry_cnt <= r_retry_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                StStable: begin
                    if (!r_locked_s) begin
                        // Lock glitched before qualifying: wait for it again without a reset.
                        r_state <= StWaitLock;
                        r_cnt   <= '0;
                    end else if (r_cnt == StableLast) begin
                        r_state     <= StRun;
                        r_cnt       <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_ready     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                StRun: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_state <= StPllRst;
                end
            endcase
        end
    end

    assign o_pll_rst       = r_pll_rst;
    assign o_sys_rst_n     = r_sys_rst_n;
    assign o_ready         = r_ready;
    assign o_lock_lost_cnt = r_lock_lost_cnt;
    assign o_retry_cnt     = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboarded bench for pll_lock_reset_seq: directed scenarios followed by random lock traffic.
module tb_pll_lock_reset_seq;

    localparam int unsigned P = 4;
    localparam int unsigned S = 8;
    localparam int unsigned T = 32;
    localparam int unsigned W = 6;

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_RUN  = 3;

    typedef logic [18:0] obs_t;  // {pll_rst, sys_rst_n, ready, lock_lost_cnt, retry_cnt}

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] lock_lost_cnt;
    logic [7:0] retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_reset_seq #(
        .PLL_RST_CYCLES     (P),
        .LOCK_STABLE_CYCLES (S),
        .LOCK_TIMEOUT_CYCLES(T),
        .CNT_W              (W)
    ) dut (
        .i_refclk       (clk),
        .i_rst_n        (rst_n),
        .i_locked       (locked),
        .i_relock_req   (relock_req),
        .o_pll_rst      (pll_rst),
        .o_sys_rst_n    (sys_rst_n),
        .o_ready        (ready),
        .o_lock_lost_cnt(lock_lost_cnt),
        .o_retry_cnt    (retry_cnt)
    );

    always #10 clk = ~clk;

    // Reference model: a phase plus the edge at which it was entered; a phase that must last
    // N cycles ends on the edge N after its entry edge. Lock is seen two edges late.
    int unsigned cyc = 0;
    int unsigned t_entry = 0;
    int          phase = PH_RST;
    bit          l1 = 1'b0;
    bit          l2 = 1'b0;
    int          lost_m = 0;
    int          retry_m = 0;
    obs_t        exp_q[$];

    function automatic obs_t model_obs();
        return {phase == PH_RST, phase == PH_RUN, phase == PH_RUN, 8'(lost_m), 8'(retry_m)};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit          ls;
        int unsigned age;
        if (!rst_n) begin
            phase   = PH_RST;
            t_entry = cyc;
            l1      = 1'b0;
            l2      = 1'b0;
            lost_m  = 0;
            retry_m = 0;
            exp_q.delete();
        end else begin
            ls  = l2;
            l2  = l1;
            l1  = locked;
            cyc = cyc + 1;
            age = cyc - t_entry;
            if (phase == PH_RUN && !ls) begin
                if (lost_m < 255) lost_m = lost_m + 1;
                phase = PH_RST; t_entry = cyc;
            end else if (relock_req) begin
                phase = PH_RST; t_entry = cyc;
            end else if (phase == PH_RST) begin
                if (age == P) begin phase = PH_WAIT; t_entry = cyc; end
            end else if (phase == PH_WAIT) begin
                if (ls) begin
                    phase = PH_STAB; t_entry = cyc;
                end else if (age == T) begin
                    if (retry_m < 255) retry_m = retry_m + 1;
                    phase = PH_RST; t_entry = cyc;
                end
            end else if (phase == PH_STAB) begin
                if (!ls) begin
                    phase = PH_WAIT; t_entry = cyc;
                end else if (age == S) begin
                    phase = PH_RUN; t_entry = cyc;
                end
            end
            exp_q.push_back(model_obs());
        end
    end

    task automatic cmp_obs(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got pll_rst=%b sys_rst_n=%b ready=%b lost=%0d retry=%0d, expected pll_rst=%b sys_rst_n=%b ready=%b lost=%0d retry=%0d",
                     name, cyc, act[18], act[17], act[16], act[15:8], act[7:0],
                     exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    // Monitor: compare every cycle's outputs against the scoreboard (reset values while held).
    always @(negedge clk) begin : monitor
        obs_t act;
        obs_t exp;
        act = {pll_rst, sys_rst_n, ready, lock_lost_cnt, retry_cnt};
        if (!rst_n) begin
            cmp_obs("in_reset", act, {1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        end else if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            cmp_obs("scoreboard", act, exp);
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns after the edge that counts as edge 0 of the new sequence.
    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        // Lock never arrives: repeated timeouts, retry count saturates.
        locked = 1'b0;
        do_reset();
        tick(3);  chk("t1_pll_rst_high", 8'(pll_rst), 8'd1);
        tick(1);  chk("t1_pll_rst_fall", 8'(pll_rst), 8'd0);
        tick(31); chk("t1_wait_pll_rst", 8'(pll_rst), 8'd0);
                  chk("t1_retry_before", retry_cnt, 8'd0);
        tick(1);  chk("t1_pll_rst_again", 8'(pll_rst), 8'd1);
                  chk("t1_retry_one", retry_cnt, 8'd1);
        tick(300 * (P + T));
        chk("t1_retry_sat", retry_cnt, 8'd255);
        chk("t1_sys_rst_n", 8'(sys_rst_n), 8'd0);

        // Lock arrives 10 cycles after pll_rst falls.
        do_reset();
        tick(14); locked = 1'b1;
        tick(10); chk("t2_sys_before", 8'(sys_rst_n), 8'd0);
        tick(1);  chk("t2_sys_release", 8'(sys_rst_n), 8'd1);
                  chk("t2_ready", 8'(ready), 8'd1);
                  chk("t2_pll_rst", 8'(pll_rst), 8'd0);

        // Lock glitch during qualification.
        locked = 1'b0;
        do_reset();
        tick(4);  locked = 1'b1;
        tick(5);  locked = 1'b0;
        tick(1);  locked = 1'b1;
        tick(10); chk("t3_sys_before", 8'(sys_rst_n), 8'd0);
        tick(1);  chk("t3_sys_release", 8'(sys_rst_n), 8'd1);
                  chk("t3_lost", lock_lost_cnt, 8'd0);

        // Lock loss in RUN.
        tick(5);  locked = 1'b0;
        tick(2);  chk("t4_sys_still", 8'(sys_rst_n), 8'd1);
        tick(1);  chk("t4_sys_fall", 8'(sys_rst_n), 8'd0);
                  chk("t4_ready_fall", 8'(ready), 8'd0);
                  chk("t4_pll_rst", 8'(pll_rst), 8'd1);
                  chk("t4_lost", lock_lost_cnt, 8'd1);
        locked = 1'b1;
        tick(3);  chk("t4_pll_hold", 8'(pll_rst), 8'd1);
        tick(1);  chk("t4_pll_fall", 8'(pll_rst), 8'd0);
        tick(8);  chk("t4_relock_before", 8'(sys_rst_n), 8'd0);
        tick(1);  chk("t4_relock", 8'(sys_rst_n), 8'd1);

        // Software relock, then relock coinciding with lock loss.
        tick(3);  relock_req = 1'b1;
        tick(1);  relock_req = 1'b0;
        chk("t5_pll_rst", 8'(pll_rst), 8'd1);
        chk("t5_sys", 8'(sys_rst_n), 8'd0);
        chk("t5_lost_same", lock_lost_cnt, 8'd1);
        tick(13); chk("t5_run_again", 8'(sys_rst_n), 8'd1);
        tick(1);  locked = 1'b0;
        tick(2);  relock_req = 1'b1;
        tick(1);  relock_req = 1'b0;
        chk("t5_both_lost", lock_lost_cnt, 8'd2);
        chk("t5_both_pll", 8'(pll_rst), 8'd1);

        // Async reset while qualifying lock (STABLE, cnt=5).
        locked = 1'b1;
        do_reset();
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("t6_pll_rst", 8'(pll_rst), 8'd1);
        chk("t6_sys", 8'(sys_rst_n), 8'd0);
        chk("t6_ready", 8'(ready), 8'd0);
        chk("t6_lost", lock_lost_cnt, 8'd0);
        chk("t6_retry", retry_cnt, 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);  chk("t6_pulse_hold", 8'(pll_rst), 8'd1);
        tick(1);  chk("t6_pulse_end", 8'(pll_rst), 8'd0);

        // Random lock traffic with occasional relock requests and async resets.
        repeat (150) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            locked = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 60)) begin
                relock_req = ($urandom_range(0, 63) == 0);
                tick(1);
            end
            relock_req = 1'b0;
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
